// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit shared definitions: op encodings,
// FSM states and default widths.
package muldiv_unit_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int TAG_W_DEF  = 3;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_MULH = 2'b01,
      OP_DIV  = 2'b10,
      OP_REM  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage
// and the iterative multiply/divide unit.
interface muldiv_unit_if
   import muldiv_unit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = TAG_W_DEF
) ();

   logic              START;
   logic              FLUSH;
   logic [1:0]        OP;
   logic              SIGNED;
   logic [DATA_W-1:0] SRC_A;
   logic [DATA_W-1:0] SRC_B;
   logic [TAG_W-1:0]  TAG_IN;
   logic              BUSY;
   logic              STALL;
   logic              DONE;
   logic [DATA_W-1:0] RESULT;
   logic [TAG_W-1:0]  TAG_OUT;
   logic              DIV0;

   modport master (
      output START, FLUSH, OP, SIGNED,
      output SRC_A, SRC_B, TAG_IN,
      input  BUSY, STALL, DONE,
      input  RESULT, TAG_OUT, DIV0
   );

   modport slave (
      input  START, FLUSH, OP, SIGNED,
      input  SRC_A, SRC_B, TAG_IN,
      output BUSY, STALL, DONE,
      output RESULT, TAG_OUT, DIV0
   );

endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for
// operand magnitudes and result sign correction.
module muldiv_negate #(
   parameter int W = 16
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add
// multiply, restoring divide, sign fix in a last cycle.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = TAG_W_DEF
) (
   input logic         CLK,
   input logic         RST_N,
   muldiv_unit_if.slave bus
);

   localparam int W     = DATA_W;
   localparam int CNT_W = $clog2(DATA_W) + 1;

   state_e             r_state;
   op_e                r_op;
   logic               r_busy;
   logic               r_done;
   logic               r_div0;
   logic               r_div0_pend;
   logic               r_sign_q;
   logic               r_sign_r;
   logic [W-1:0]       r_result;
   logic [W-1:0]       r_opnd;
   logic [W-1:0]       r_rem;
   logic [2*W-1:0]     r_acc;
   logic [TAG_W-1:0]   r_tag;
   logic [TAG_W-1:0]   r_tag_out;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_accept;
   logic               w_sa;
   logic               w_sb;
   logic [W-1:0]       w_mag_a;
   logic [W-1:0]       w_mag_b;
   logic [W:0]         w_msum;
   logic [W:0]         w_dsh;
   logic [W:0]         w_ddif;
   logic               w_dok;
   logic [2*W-1:0]     w_prod;
   logic [W-1:0]       w_quo;
   logic [W-1:0]       w_rem;
   logic [W-1:0]       w_res;

   assign w_accept = bus.START & ~bus.FLUSH;
   assign w_sa = bus.SIGNED & bus.SRC_A[W-1];
   assign w_sb = bus.SIGNED & bus.SRC_B[W-1];

   muldiv_negate #(.W(W)) u_neg_a (
      .i_val(bus.SRC_A), .i_neg(w_sa), .o_val(w_mag_a)
   );
   muldiv_negate #(.W(W)) u_neg_b (
      .i_val(bus.SRC_B), .i_neg(w_sb), .o_val(w_mag_b)
   );
   muldiv_negate #(.W(2*W)) u_neg_p (
      .i_val(r_acc), .i_neg(r_sign_q), .o_val(w_prod)
   );
   muldiv_negate #(.W(W)) u_neg_q (
      .i_val(r_acc[W-1:0]), .i_neg(r_sign_q), .o_val(w_quo)
   );
   muldiv_negate #(.W(W)) u_neg_r (
      .i_val(r_rem), .i_neg(r_sign_r), .o_val(w_rem)
   );

   // Multiply: r_acc = {partial product, multiplier}
   assign w_msum = {1'b0, r_acc[2*W-1:W]}
                 + (r_acc[0] ? {1'b0, r_opnd} : '0);
   // Divide: r_acc[W-1:0] shifts dividend out, quotient in
   assign w_dsh  = {r_rem, r_acc[W-1]};
   assign w_ddif = w_dsh - {1'b0, r_opnd};
   assign w_dok  = ~w_ddif[W];

   always_comb begin
      w_res = w_prod[W-1:0];
      unique case (r_op)
         OP_MUL:  w_res = w_prod[W-1:0];
         OP_MULH: w_res = w_prod[2*W-1:W];
         OP_DIV:  w_res = r_div0_pend ? '1 : w_quo;
         OP_REM:  w_res = w_rem;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= S_IDLE;
         r_op        <= OP_MUL;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div0      <= 1'b0;
         r_div0_pend <= 1'b0;
         r_sign_q    <= 1'b0;
         r_sign_r    <= 1'b0;
         r_result    <= '0;
         r_opnd      <= '0;
         r_rem       <= '0;
         r_acc       <= '0;
         r_tag       <= '0;
         r_tag_out   <= '0;
         r_cnt       <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_CALC;
                  r_busy      <= 1'b1;
                  r_op        <= op_e'(bus.OP);
                  r_tag       <= bus.TAG_IN;
                  r_cnt       <= CNT_W'(W);
                  r_rem       <= '0;
                  r_sign_q    <= w_sa ^ w_sb;
                  r_sign_r    <= w_sa;
                  r_div0_pend <= bus.OP[1]
                               & (bus.SRC_B == '0);
                  if (bus.OP[1]) begin
                     r_acc  <= {{W{1'b0}}, w_mag_a};
                     r_opnd <= w_mag_b;
                  end else begin
                     r_acc  <= {{W{1'b0}}, w_mag_b};
                     r_opnd <= w_mag_a;
                  end
               end
            end
            S_CALC: begin
               if (bus.FLUSH) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_op[1]) begin
                     r_rem <= w_dok ? w_ddif[W-1:0]
                                    : w_dsh[W-1:0];
                     r_acc[W-1:0] <= {r_acc[W-2:0], w_dok};
                  end else begin
                     r_acc <= {w_msum, r_acc[W-1:1]};
                  end
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1))
                     r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               if (!bus.FLUSH) begin
                  r_result  <= w_res;
                  r_tag_out <= r_tag;
                  r_div0    <= r_div0_pend;
                  r_done    <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.BUSY    = r_busy;
   assign bus.STALL   = ((r_state == S_IDLE) & w_accept)
                      | r_busy;
   assign bus.DONE    = r_done;
   assign bus.RESULT  = r_result;
   assign bus.TAG_OUT = r_tag_out;
   assign bus.DIV0    = r_div0;

endmodule
